// File: rtl/cla_subtractor_seq_if.sv
// rtl/cla_subtractor_seq_if.sv - operand/result handshake bundle for cla_subtractor_seq
interface cla_subtractor_seq_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_sub1;
  logic [WIDTH-1:0] i_sub2;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH:0]   o_result;

  modport slave (
    input  i_valid,
    input  i_sub1,
    input  i_sub2,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_result
  );

  modport master (
    output i_valid,
    output i_sub1,
    output i_sub2,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_result
  );
endinterface

// File: rtl/cla_subtractor_seq.sv
// rtl/cla_subtractor_seq.sv - multi-cycle unsigned subtractor, one carry-lookahead slice per cycle
module cla_subtractor_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_subtractor_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("cla_subtractor_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [CW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH:0]   result_q;
  logic             ready_c;
  logic             valid_c;

  logic [31:0]      base;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_g;
  logic [CHUNK-1:0] slice_p;
  logic [CHUNK:0]   slice_c;
  logic [CHUNK-1:0] slice_sum;
  logic             last_slice;

  // Each carry is a flat sum-of-products of g/p/cin, so no carry waits on its neighbour.
  function automatic logic [CHUNK:0] lookahead(
    input logic [CHUNK-1:0] g,
    input logic [CHUNK-1:0] p,
    input logic             cin
  );
    logic [CHUNK:0] c;
    logic           acc;
    logic           term;
    c    = '0;
    c[0] = cin;
    for (int j = 0; j < CHUNK; j++) begin
      acc = cin;
      for (int k = 0; k <= j; k++) acc = acc & p[k];
      for (int i = 0; i <= j; i++) begin
        term = g[i];
        for (int k = i + 1; k <= j; k++) term = term & p[k];
        acc = acc | term;
      end
      c[j+1] = acc;
    end
    return c;
  endfunction

  assign base       = 32'(idx_q) * 32'(CHUNK);
  assign slice_a    = op_a_q[base +: CHUNK];
  assign slice_b    = op_b_q[base +: CHUNK];
  assign last_slice = (idx_q == LAST_IDX);

  always_comb begin
    slice_g   = slice_a & slice_b;
    slice_p   = slice_a | slice_b;
    slice_c   = lookahead(slice_g, slice_p, carry_q);
    slice_sum = slice_a ^ slice_b ^ slice_c[CHUNK-1:0];
    work_d    = work_q;
    work_d[base +: CHUNK] = slice_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.i_valid) state_d = CALC;
      end
      CALC: begin
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        valid_c = 1'b1;
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtrahend is stored inverted and the carry seeded with 1: a - b = a + ~b + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      work_q   <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b1;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            op_a_q  <= bus.i_sub1;
            op_b_q  <= ~bus.i_sub2;
            work_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b1;
          end
        end
        CALC: begin
          work_q  <= work_d;
          carry_q <= slice_c[CHUNK];
          if (last_slice) begin
            idx_q    <= '0;
            result_q <= {~slice_c[CHUNK], work_d};
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready  = ready_c;
  assign bus.o_valid  = valid_c;
  assign bus.o_result = result_q;

endmodule

// File: tb/tb_cla_subtractor_seq.sv
// tb/tb_cla_subtractor_seq.sv - self-checking bench for cla_subtractor_seq
module tb_cla_subtractor_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [16:0] sb16[$];
  logic [8:0]  sb8[$];
  logic [64:0] sb64[$];

  cla_subtractor_seq_if #(.WIDTH(16)) b16();
  cla_subtractor_seq_if #(.WIDTH(8))  b8();
  cla_subtractor_seq_if #(.WIDTH(64)) b64();

  cla_subtractor_seq #(.WIDTH(16), .CHUNK(4))  dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  cla_subtractor_seq #(.WIDTH(8),  .CHUNK(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  cla_subtractor_seq #(.WIDTH(64), .CHUNK(16)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    d = a - b;
    return {(a < b), d};
  endfunction

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    return {(a < b), d};
  endfunction

  function automatic logic [64:0] model64(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] d;
    d = a - b;
    return {(a < b), d};
  endfunction

  task automatic drive_op16(input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp);
    @(negedge clk);
    for (int n = 0; n < 64 && !b16.o_ready; n++) @(negedge clk);
    b16.i_valid = 1'b1;
    b16.i_sub1  = a;
    b16.i_sub2  = b;
    sb16.push_back(exp);
    @(posedge clk);
    #1;
    b16.i_valid = 1'b0;
  endtask

  task automatic wait_valid16(output int lat);
    lat = -1;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk);
      #1;
      if (b16.o_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b16.i_valid = 1'b1; b16.i_ready = 1'b1; b16.i_sub1 = 16'h1234; b16.i_sub2 = 16'h0001;
    b8.i_valid  = 1'b0; b8.i_ready  = 1'b0; b8.i_sub1  = '0; b8.i_sub2  = '0;
    b64.i_valid = 1'b0; b64.i_ready = 1'b0; b64.i_sub1 = '0; b64.i_sub2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (b16.o_ready !== 1'b1 || b16.o_valid !== 1'b0 || b16.o_result !== 17'h0) begin
      failures++;
      $display("FAIL reset16 ready=%b valid=%b result=%h expected ready=1 valid=0 result=00000",
               b16.o_ready, b16.o_valid, b16.o_result);
    end
    checks++;
    if (b8.o_ready !== 1'b1 || b8.o_valid !== 1'b0 || b8.o_result !== 9'h0) begin
      failures++;
      $display("FAIL reset8 ready=%b valid=%b result=%h expected 1/0/000", b8.o_ready, b8.o_valid, b8.o_result);
    end
    checks++;
    if (b64.o_ready !== 1'b1 || b64.o_valid !== 1'b0 || b64.o_result !== 65'h0) begin
      failures++;
      $display("FAIL reset64 ready=%b valid=%b result=%h expected 1/0/0", b64.o_ready, b64.o_valid, b64.o_result);
    end
    b16.i_valid = 1'b0;
    b16.i_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] va[4];
    logic [15:0] vb[4];
    logic [16:0] ve[4];
    logic [16:0] exp;
    int          lat;
    va = '{16'h1234, 16'h0000, 16'h1000, 16'h8000};
    vb = '{16'h0034, 16'h0001, 16'h0001, 16'h8000};
    ve = '{17'h0_1200, 17'h1_FFFF, 17'h0_0FFF, 17'h0_0000};
    b16.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_op16(va[i], vb[i], ve[i]);
      wait_valid16(lat);
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL basic_latency[%0d] got=%0d expected=4", i, lat);
      end
      exp = sb16.pop_front();
      checks++;
      if (b16.o_result !== exp) begin
        failures++;
        $display("FAIL basic_result[%0d] got=%h expected=%h", i, b16.o_result, exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (b16.o_valid !== 1'b0 || b16.o_ready !== 1'b1) begin
        failures++;
        $display("FAIL basic_handshake[%0d] valid=%b ready=%b expected valid=0 ready=1", i, b16.o_valid, b16.o_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    int          lat;
    b16.i_ready = 1'b0;
    drive_op16(16'hFFFF, 16'h0001, 17'h0_FFFE);
    wait_valid16(lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL bp_latency got=%0d expected=4", lat);
    end
    exp = sb16.pop_front();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b16.i_valid = 1'b1;
      b16.i_sub1  = 16'h0F0F;
      b16.i_sub2  = 16'h1111;
      @(posedge clk);
      #1;
      checks++;
      if (b16.o_valid !== 1'b1 || b16.o_ready !== 1'b0 || b16.o_result !== exp) begin
        failures++;
        $display("FAIL bp_hold[%0d] valid=%b ready=%b result=%h expected valid=1 ready=0 result=%h",
                 i, b16.o_valid, b16.o_ready, b16.o_result, exp);
      end
    end
    @(negedge clk);
    b16.i_valid = 1'b0;
    b16.i_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (b16.o_valid !== 1'b0 || b16.o_ready !== 1'b1 || b16.o_result !== exp) begin
      failures++;
      $display("FAIL bp_release valid=%b ready=%b result=%h expected valid=0 ready=1 result=%h",
               b16.o_valid, b16.o_ready, b16.o_result, exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b16.o_valid !== 1'b0 || b16.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_single_transfer valid=%b ready=%b expected valid=0 ready=1", b16.o_valid, b16.o_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [16:0] exp;
    int          lat;
    b16.i_ready = 1'b1;
    drive_op16(16'hABCD, 16'h1234, model16(16'hABCD, 16'h1234));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b16.o_valid !== 1'b0 || b16.o_result !== 17'h0 || b16.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_op valid=%b result=%h ready=%b expected valid=0 result=00000 ready=1",
               b16.o_valid, b16.o_result, b16.o_ready);
    end
    sb16.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_op16(16'h0005, 16'h0007, 17'h1_FFFE);
    wait_valid16(lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL post_reset_latency got=%0d expected=4", lat);
    end
    exp = sb16.pop_front();
    checks++;
    if (b16.o_result !== exp) begin
      failures++;
      $display("FAIL post_reset_result got=%h expected=%h", b16.o_result, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp;
    int          sent;
    int          recv;
    int          cyc;
    int          last_acc;
    sent = 0; recv = 0; cyc = 0; last_acc = -100;
    a = 16'($urandom);
    b = 16'($urandom);
    @(negedge clk);
    while (recv < 1000 && cyc < 20000) begin
      b16.i_ready = 1'($urandom_range(0, 1));
      if (sent < 1000) begin
        b16.i_valid = 1'b1;
        b16.i_sub1  = a;
        b16.i_sub2  = b;
      end else begin
        b16.i_valid = 1'b0;
      end
      if (b16.o_ready && b16.i_valid) begin
        checks++;
        if (cyc - last_acc < 5) begin
          failures++;
          $display("FAIL b2b_spacing accept gap=%0d expected>=5", cyc - last_acc);
        end
        last_acc = cyc;
        sb16.push_back(model16(a, b));
        sent++;
        a = 16'($urandom);
        b = 16'($urandom);
      end
      if (b16.o_valid && b16.i_ready) begin
        checks++;
        if (sb16.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra_result got=%h expected=no result", b16.o_result);
        end else begin
          exp = sb16.pop_front();
          if (b16.o_result !== exp) begin
            failures++;
            $display("FAIL b2b_result[%0d] got=%h expected=%h", recv, b16.o_result, exp);
          end
        end
        recv++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (recv != 1000 || sent != 1000 || sb16.size() != 0) begin
      failures++;
      $display("FAIL b2b_count received=%0d sent=%0d pending=%0d expected 1000/1000/0", recv, sent, sb16.size());
    end
    b16.i_valid = 1'b0;
    b16.i_ready = 1'b0;
  endtask

  task automatic test_sweep_w8();
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
    int         lat;
    b8.i_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = (i == 0) ? 8'h5A : (i == 1) ? 8'h00 : 8'($urandom);
      b = (i == 0) ? 8'h5A : (i == 1) ? 8'hFF : 8'($urandom);
      @(negedge clk);
      b8.i_valid = 1'b1; b8.i_sub1 = a; b8.i_sub2 = b;
      sb8.push_back(model8(a, b));
      @(posedge clk);
      #1;
      b8.i_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 16; n++) begin
        @(posedge clk);
        #1;
        if (b8.o_valid) begin lat = n; break; end
      end
      exp = sb8.pop_front();
      checks++;
      if (lat !== 1 || b8.o_result !== exp) begin
        failures++;
        $display("FAIL sweep8[%0d] latency=%0d result=%h expected latency=1 result=%h", i, lat, b8.o_result, exp);
      end
      @(posedge clk);
      #1;
    end
    b8.i_ready = 1'b0;
  endtask

  task automatic test_sweep_w64();
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] exp;
    int          lat;
    b64.i_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = (i == 0) ? 64'h0 : (i == 1) ? 64'h0001_0000_0000_0000 : {$urandom, $urandom};
      b = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (i == 1) ? 64'h1 : {$urandom, $urandom};
      @(negedge clk);
      b64.i_valid = 1'b1; b64.i_sub1 = a; b64.i_sub2 = b;
      sb64.push_back(model64(a, b));
      @(posedge clk);
      #1;
      b64.i_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 16; n++) begin
        @(posedge clk);
        #1;
        if (b64.o_valid) begin lat = n; break; end
      end
      exp = sb64.pop_front();
      checks++;
      if (lat !== 4 || b64.o_result !== exp) begin
        failures++;
        $display("FAIL sweep64[%0d] latency=%0d result=%h expected latency=4 result=%h", i, lat, b64.o_result, exp);
      end
      @(posedge clk);
      #1;
    end
    b64.i_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_sweep_w8();
    test_sweep_w64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
